// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: synchronise, glitch-filter, x4 decode into step/ud plus position.
// Optional index input (enc_z / idx) is compiled in when QDEC_INDEX_EN is defined.
module quad_step_decoder #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
`ifdef QDEC_INDEX_EN
  input  logic             enc_z,
`endif
  input  logic             clr,
  output logic             step,
  output logic             ud,
  output logic [CNT_W-1:0] pos,
  output logic             err,
  output logic             err_sticky,
`ifdef QDEC_INDEX_EN
  output logic             idx,
`endif
  output logic             valid
);

`ifdef QDEC_INDEX_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 2;
`endif
  localparam int FC_W   = $clog2(FILT_LEN + 1);
  localparam int WARM   = SYNC_STAGES + FILT_LEN;
  localparam int WARM_W = $clog2(WARM + 1);
  localparam logic [FC_W-1:0]   FILT_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [FC_W-1:0]   FC_ONE    = {{(FC_W-1){1'b0}}, 1'b1};
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM);
  localparam logic [WARM_W-1:0] WARM_ONE  = {{(WARM_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  POS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;

  // True when {A,B} moved one step in the A-leads-B direction.
  function automatic logic is_up(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: is_up = 1'b1;
      default:                            is_up = 1'b0;
    endcase
  endfunction

  logic [NPH-1:0] raw_s;
  logic [NPH-1:0] sync_s;
  logic [NPH-1:0] filt_s;
  logic [1:0]     cur_s;

`ifdef QDEC_INDEX_EN
  assign raw_s = {enc_z, enc_b, enc_a};
`else
  assign raw_s = {enc_b, enc_a};
`endif

  for (genvar g = 0; g < NPH; g++) begin : g_ph
    logic [SYNC_STAGES-1:0] sync_r;
    logic [FC_W-1:0]        fcnt_r;
    logic                   filt_r;

    // Plain synchroniser chain, then count consecutive disagreeing samples before accepting them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r <= '0;
        fcnt_r <= '0;
        filt_r <= 1'b0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[g]};
        if (sync_r[SYNC_STAGES-1] == filt_r) begin
          fcnt_r <= '0;
        end else if (fcnt_r == FILT_LAST) begin
          fcnt_r <= '0;
          filt_r <= sync_r[SYNC_STAGES-1];
        end else begin
          fcnt_r <= fcnt_r + FC_ONE;
        end
      end
    end

    assign sync_s[g] = sync_r[SYNC_STAGES-1];
    assign filt_s[g] = filt_r;
  end

  assign cur_s = {filt_s[0], filt_s[1]};

  state_t            state_r, state_s;
  logic [1:0]        prev_r, prev_s;
  logic [WARM_W-1:0] warm_r, warm_s;
  logic              step_r, step_s;
  logic              ud_r, ud_s;
  logic [CNT_W-1:0]  pos_r, pos_s;
  logic              err_r, err_s;
  logic              sticky_r, sticky_s;
  logic              valid_r, valid_s;
`ifdef QDEC_INDEX_EN
  logic              zprev_r;
  logic              idx_r, idx_s;
  logic              z_rise_s;
  assign z_rise_s = filt_s[2] & ~zprev_r;
`endif

  // Next-state and decode; clr is folded in at the register stage below.
  always_comb begin
    state_s  = state_r;
    prev_s   = prev_r;
    warm_s   = warm_r;
    step_s   = 1'b0;
    ud_s     = ud_r;
    pos_s    = pos_r;
    err_s    = 1'b0;
    sticky_s = sticky_r;
    valid_s  = valid_r;
`ifdef QDEC_INDEX_EN
    idx_s    = 1'b0;
`endif
    case (state_r)
      ST_INIT: begin
        if (warm_r != WARM_DONE) begin
          warm_s = warm_r + WARM_ONE;
        end else begin
          warm_s = warm_r;
        end
        // Leave only once the sync chain is full and no phase is still qualifying.
        if ((warm_r == WARM_DONE) && (sync_s == filt_s)) begin
          state_s = ST_TRACK;
          prev_s  = cur_s;
          valid_s = 1'b1;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_TRACK: begin
        prev_s = cur_s;
        if (is_up(prev_r, cur_s)) begin
          step_s = 1'b1;
          ud_s   = 1'b1;
          pos_s  = pos_r + POS_ONE;
        end else if (is_up(cur_s, prev_r)) begin
          step_s = 1'b1;
          ud_s   = 1'b0;
          pos_s  = pos_r - POS_ONE;
        end else if ((prev_r ^ cur_s) == 2'b11) begin
          err_s    = 1'b1;
          sticky_s = 1'b1;
        end else begin
          step_s = 1'b0;
        end
`ifdef QDEC_INDEX_EN
        if (z_rise_s) begin
          idx_s = 1'b1;
          pos_s = '0;
        end else begin
          idx_s = 1'b0;
        end
`endif
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_INIT;
      prev_r   <= 2'b00;
      warm_r   <= '0;
      step_r   <= 1'b0;
      ud_r     <= 1'b0;
      pos_r    <= '0;
      err_r    <= 1'b0;
      sticky_r <= 1'b0;
      valid_r  <= 1'b0;
`ifdef QDEC_INDEX_EN
      zprev_r  <= 1'b0;
      idx_r    <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      prev_r  <= prev_s;
      warm_r  <= warm_s;
      step_r  <= step_s;
      ud_r    <= ud_s;
      err_r   <= err_s;
      valid_r <= valid_s;
      if (clr) begin
        pos_r    <= '0;
        sticky_r <= 1'b0;
      end else begin
        pos_r    <= pos_s;
        sticky_r <= sticky_s;
      end
`ifdef QDEC_INDEX_EN
      zprev_r <= filt_s[2];
      idx_r   <= idx_s;
`endif
    end
  end

  assign step       = step_r;
  assign ud         = ud_r;
  assign pos        = pos_r;
  assign err        = err_r;
  assign err_sticky = sticky_r;
  assign valid      = valid_r;
`ifdef QDEC_INDEX_EN
  assign idx        = idx_r;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with default parameters (CNT_W=4, SYNC_STAGES=2, FILT_LEN=2).
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enc_a;
  logic       enc_b;
  logic       clr;
  logic       step;
  logic       ud;
  logic [3:0] pos;
  logic       err;
  logic       err_sticky;
  logic       valid;
`ifdef QDEC_INDEX_EN
  logic       enc_z;
  logic       idx;
  int         idx_cnt = 0;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  int         step_cnt = 0;
  int         err_cnt  = 0;
  int         snap_step;
  logic [3:0] exp_pos;
  logic [1:0] cur_ab;

  quad_step_decoder #(.CNT_W(4), .SYNC_STAGES(2), .FILT_LEN(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
`ifdef QDEC_INDEX_EN
    .enc_z      (enc_z),
`endif
    .clr        (clr),
    .step       (step),
    .ud         (ud),
    .pos        (pos),
    .err        (err),
    .err_sticky (err_sticky),
`ifdef QDEC_INDEX_EN
    .idx        (idx),
`endif
    .valid      (valid)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (err === 1'b1) err_cnt++;
`ifdef QDEC_INDEX_EN
    if (idx === 1'b1) idx_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    enc_a  = ab[1];
    enc_b  = ab[0];
    cur_ab = ab;
  endtask

  function automatic logic [1:0] next_up(input logic [1:0] ab);
    case (ab)
      2'b00:   next_up = 2'b10;
      2'b10:   next_up = 2'b11;
      2'b11:   next_up = 2'b01;
      default: next_up = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] next_dn(input logic [1:0] ab);
    case (ab)
      2'b00:   next_dn = 2'b01;
      2'b01:   next_dn = 2'b11;
      2'b11:   next_dn = 2'b10;
      default: next_dn = 2'b00;
    endcase
  endfunction

  // One legal edge held 8 cycles; step expected exactly 5 cycles after the input change.
  task automatic edge_step(input logic up, input logic with_clr);
    logic [1:0] nxt;
    nxt = up ? next_up(cur_ab) : next_dn(cur_ab);
    drive_ab(nxt);
    tick(4);
    check("step_early", step, 0);
    if (with_clr) clr = 1'b1;
    tick(1);
    clr = 1'b0;
    if (with_clr) exp_pos = 4'd0;
    else if (up) exp_pos = exp_pos + 4'd1;
    else exp_pos = exp_pos - 4'd1;
    check("step", step, 1);
    check("ud", ud, up);
    check("pos", pos, exp_pos);
    tick(1);
    check("step_width", step, 0);
    tick(2);
  endtask

  // Both phases flip together: err pulse, no step, pos and ud held.
  task automatic edge_jump(input logic exp_ud);
    drive_ab(~cur_ab);
    tick(4);
    check("err_early", err, 0);
    tick(1);
    check("err", err, 1);
    check("err_step", step, 0);
    check("err_sticky", err_sticky, 1);
    check("err_pos", pos, exp_pos);
    check("err_ud", ud, exp_ud);
    tick(1);
    check("err_width", err, 0);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
`ifdef QDEC_INDEX_EN
    enc_z = 1'b0;
`endif
    drive_ab(2'b11);
    exp_pos = 4'd0;
    tick(3);
    check("rst_step", step, 0);
    check("rst_ud", ud, 0);
    check("rst_pos", pos, 0);
    check("rst_err", err, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_valid", valid, 0);
    rst_n = 1'b1;
    tick(10);
    check("init11_valid", valid, 1);
    check("init11_steps", step_cnt, 0);
    check("init11_errs", err_cnt, 0);
    check("init11_pos", pos, 0);

    // Async reset mid-cycle, then restart from 00.
    #2 rst_n = 1'b0;
    #1 check("async_valid", valid, 0);
    drive_ab(2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("init00_valid", valid, 1);
    check("init00_steps", step_cnt, 0);
    check("init00_errs", err_cnt, 0);

    for (int i = 0; i < 20; i++) edge_step(1'b1, 1'b0);
    check("up20_count", step_cnt, 20);
    check("up20_pos", pos, 4);
    check("up20_ud", ud, 1);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_pos = 4'd0;
    check("clr_pos", pos, 0);

    edge_step(1'b0, 1'b0);
    check("wrap_down", pos, 15);

    snap_step = step_cnt;
    enc_a = ~enc_a;
    tick(1);
    enc_a = cur_ab[1];
    tick(10);
    check("glitch_steps", step_cnt, snap_step);
    check("glitch_errs", err_cnt, 0);
    check("glitch_pos", pos, 15);

    edge_jump(1'b0);
    edge_step(1'b0, 1'b0);
    edge_jump(1'b0);
    check("jump_count", err_cnt, 2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_pos = 4'd0;
    check("clr_sticky", err_sticky, 0);
    check("clr_pos2", pos, 0);

    for (int i = 0; i < 7; i++) edge_step(1'b1, 1'b0);
    check("pos7", pos, 7);
    edge_step(1'b1, 1'b1);

`ifdef QDEC_INDEX_EN
    for (int i = 0; i < 9; i++) edge_step(1'b1, 1'b0);
    check("pos9", pos, 9);
    enc_z = 1'b1;
    tick(4);
    check("idx_early", idx, 0);
    enc_z = 1'b0;
    tick(1);
    exp_pos = 4'd0;
    check("idx", idx, 1);
    check("idx_pos", pos, 0);
    tick(10);
    check("idx_count", idx_cnt, 1);
    edge_step(1'b1, 1'b0);
    check("idx_next", pos, 1);
`endif

    edge_step(1'b1, 1'b0);
    edge_step(1'b1, 1'b0);
    snap_step = step_cnt;
    #2 rst_n = 1'b0;
    #1 check("midrst_pos", pos, 0);
    check("midrst_valid", valid, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("rerun_valid", valid, 1);
    check("rerun_steps", step_cnt, snap_step);
    check("rerun_errs", err_cnt, 2);
    check("rerun_pos", pos, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
